// File: rtl/matrix_row_bank.sv
// Row-organised register bank shared by the host, the lu engine and the
// triangular-inverse engine, with an ownership FSM granting one client at a time.
module matrix_row_bank #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64,
  localparam int ROW_W = SIZE * 2 * WIDTH,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             host_wr_valid_i,
  input  logic [AW-1:0]    host_wr_addr_i,
  input  logic [ROW_W-1:0] host_wr_row_i,
  output logic             host_wr_ready_o,
  input  logic             host_rd_valid_i,
  input  logic [AW-1:0]    host_rd_addr_i,
  output logic             host_rd_valid_o,
  output logic [AW-1:0]    host_rd_addr_o,
  output logic [ROW_W-1:0] host_rd_row_o,
  input  logic             clear_i,
  output logic             full_o,
  input  logic             start_lu_i,
  input  logic             start_inv_i,
  output logic             lu_start_o,
  output logic             inv_start_o,
  input  logic             lu_busy_i,
  input  logic             inv_busy_i,
  input  logic             lu_rd_valid_i,
  input  logic [AW-1:0]    lu_rd_addr_i,
  output logic             lu_rd_valid_o,
  output logic [AW-1:0]    lu_rd_addr_o,
  output logic [ROW_W-1:0] lu_rd_row_o,
  input  logic             lu_wr_valid_i,
  input  logic [AW-1:0]    lu_wr_addr_i,
  input  logic [ROW_W-1:0] lu_wr_row_i,
  output logic             lu_wr_ready_o,
  input  logic             inv_rd_valid_i,
  input  logic [AW-1:0]    inv_rd_addr_i,
  output logic             inv_rd_valid_o,
  output logic [AW-1:0]    inv_rd_addr_o,
  output logic [ROW_W-1:0] inv_rd_row_o,
  output logic [1:0]       owner_o,
  output logic             err_o
);

  typedef enum logic [2:0] {IDLE, LU_WAIT, LU_RUN, INV_WAIT, INV_RUN} state_t;

  state_t           state;
  logic [SIZE-1:0]  bitmap;
  logic [3:0]       wait_cnt;
  logic [ROW_W-1:0] mem [SIZE];

  logic is_idle, own_lu, own_inv;
  logic host_wr_ok, host_rd_ok, lu_wr_ok, lu_rd_ok, inv_rd_ok;
  logic proto_err;

  // Handshake: a write is accepted on any edge where valid and ready are both
  // high; read requests have no ready and are answered exactly one cycle later.
  assign is_idle = (state == IDLE);
  assign own_lu  = (state == LU_WAIT) || (state == LU_RUN);
  assign own_inv = (state == INV_WAIT) || (state == INV_RUN);

  assign host_wr_ready_o = is_idle;
  assign lu_wr_ready_o   = own_lu;
  assign full_o          = &bitmap;
  assign owner_o         = own_lu ? 2'd1 : (own_inv ? 2'd2 : 2'd0);

  assign host_wr_ok = host_wr_valid_i && is_idle;
  assign host_rd_ok = host_rd_valid_i && is_idle;
  assign lu_wr_ok   = lu_wr_valid_i && own_lu;
  assign lu_rd_ok   = lu_rd_valid_i && own_lu;
  assign inv_rd_ok  = inv_rd_valid_i && own_inv;

  assign proto_err = (host_wr_valid_i && !is_idle) || (host_rd_valid_i && !is_idle) ||
                     (lu_wr_valid_i && !own_lu) || (lu_rd_valid_i && !own_lu) ||
                     (inv_rd_valid_i && !own_inv) ||
                     (is_idle && (start_lu_i || start_inv_i) && !full_o);

  // Storage and read data are not reset; reads see the pre-write row.
  always_ff @(posedge clk_i) begin
    if (host_wr_ok) mem[host_wr_addr_i] <= host_wr_row_i;
    if (lu_wr_ok)   mem[lu_wr_addr_i]   <= lu_wr_row_i;
    host_rd_row_o  <= mem[host_rd_addr_i];
    host_rd_addr_o <= host_rd_addr_i;
    lu_rd_row_o    <= mem[lu_rd_addr_i];
    lu_rd_addr_o   <= lu_rd_addr_i;
    inv_rd_row_o   <= mem[inv_rd_addr_i];
    inv_rd_addr_o  <= inv_rd_addr_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state           <= IDLE;
      bitmap          <= '0;
      wait_cnt        <= '0;
      err_o           <= 1'b0;
      lu_start_o      <= 1'b0;
      inv_start_o     <= 1'b0;
      host_rd_valid_o <= 1'b0;
      lu_rd_valid_o   <= 1'b0;
      inv_rd_valid_o  <= 1'b0;
    end else begin
      lu_start_o      <= 1'b0;
      inv_start_o     <= 1'b0;
      host_rd_valid_o <= host_rd_ok;
      lu_rd_valid_o   <= lu_rd_ok;
      inv_rd_valid_o  <= inv_rd_ok;
      if (proto_err) err_o <= 1'b1;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (clear_i) bitmap <= '0;
          else if (host_wr_valid_i) bitmap[host_wr_addr_i] <= 1'b1;
          if (full_o && start_lu_i) begin
            state      <= LU_WAIT;
            lu_start_o <= 1'b1;
          end else if (full_o && start_inv_i) begin
            state       <= INV_WAIT;
            inv_start_o <= 1'b1;
          end
        end
        LU_WAIT: begin
          if (lu_busy_i) state <= LU_RUN;
          else if (wait_cnt == 4'd15) begin
            state <= IDLE;
            err_o <= 1'b1;
          end else wait_cnt <= wait_cnt + 4'd1;
        end
        LU_RUN: if (!lu_busy_i) state <= IDLE;
        INV_WAIT: begin
          if (inv_busy_i) state <= INV_RUN;
          else if (wait_cnt == 4'd15) begin
            state <= IDLE;
            err_o <= 1'b1;
          end else wait_cnt <= wait_cnt + 4'd1;
        end
        INV_RUN: if (!inv_busy_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_row_bank.sv
// Bench for matrix_row_bank: randomized rows checked against an array model
// of the bank contents, written-row set and sticky error flag.
module tb_matrix_row_bank;
  localparam int SIZE  = 16;
  localparam int WIDTH = 16;
  localparam int ROW_W = SIZE * 2 * WIDTH;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             host_wr_valid_i;
  logic [AW-1:0]    host_wr_addr_i;
  logic [ROW_W-1:0] host_wr_row_i;
  logic             host_wr_ready_o;
  logic             host_rd_valid_i;
  logic [AW-1:0]    host_rd_addr_i;
  logic             host_rd_valid_o;
  logic [AW-1:0]    host_rd_addr_o;
  logic [ROW_W-1:0] host_rd_row_o;
  logic             clear_i;
  logic             full_o;
  logic             start_lu_i, start_inv_i;
  logic             lu_start_o, inv_start_o;
  logic             lu_busy_i, inv_busy_i;
  logic             lu_rd_valid_i;
  logic [AW-1:0]    lu_rd_addr_i;
  logic             lu_rd_valid_o;
  logic [AW-1:0]    lu_rd_addr_o;
  logic [ROW_W-1:0] lu_rd_row_o;
  logic             lu_wr_valid_i;
  logic [AW-1:0]    lu_wr_addr_i;
  logic [ROW_W-1:0] lu_wr_row_i;
  logic             lu_wr_ready_o;
  logic             inv_rd_valid_i;
  logic [AW-1:0]    inv_rd_addr_i;
  logic             inv_rd_valid_o;
  logic [AW-1:0]    inv_rd_addr_o;
  logic [ROW_W-1:0] inv_rd_row_o;
  logic [1:0]       owner_o;
  logic             err_o;

  matrix_row_bank #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .host_wr_valid_i(host_wr_valid_i), .host_wr_addr_i(host_wr_addr_i),
    .host_wr_row_i(host_wr_row_i), .host_wr_ready_o(host_wr_ready_o),
    .host_rd_valid_i(host_rd_valid_i), .host_rd_addr_i(host_rd_addr_i),
    .host_rd_valid_o(host_rd_valid_o), .host_rd_addr_o(host_rd_addr_o),
    .host_rd_row_o(host_rd_row_o), .clear_i(clear_i), .full_o(full_o),
    .start_lu_i(start_lu_i), .start_inv_i(start_inv_i),
    .lu_start_o(lu_start_o), .inv_start_o(inv_start_o),
    .lu_busy_i(lu_busy_i), .inv_busy_i(inv_busy_i),
    .lu_rd_valid_i(lu_rd_valid_i), .lu_rd_addr_i(lu_rd_addr_i),
    .lu_rd_valid_o(lu_rd_valid_o), .lu_rd_addr_o(lu_rd_addr_o), .lu_rd_row_o(lu_rd_row_o),
    .lu_wr_valid_i(lu_wr_valid_i), .lu_wr_addr_i(lu_wr_addr_i),
    .lu_wr_row_i(lu_wr_row_i), .lu_wr_ready_o(lu_wr_ready_o),
    .inv_rd_valid_i(inv_rd_valid_i), .inv_rd_addr_i(inv_rd_addr_i),
    .inv_rd_valid_o(inv_rd_valid_o), .inv_rd_addr_o(inv_rd_addr_o),
    .inv_rd_row_o(inv_rd_row_o), .owner_o(owner_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  logic [ROW_W-1:0] ref_mem [SIZE];
  logic [SIZE-1:0]  ref_written;
  logic             exp_err;
  logic [ROW_W-1:0] exp_q[$];
  logic [ROW_W-1:0] exp_row;
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_wr_valid_i = 0; host_wr_addr_i = '0; host_wr_row_i = '0;
    host_rd_valid_i = 0; host_rd_addr_i = '0; clear_i = 0;
    start_lu_i = 0; start_inv_i = 0; lu_busy_i = 0; inv_busy_i = 0;
    lu_rd_valid_i = 0; lu_rd_addr_i = '0;
    lu_wr_valid_i = 0; lu_wr_addr_i = '0; lu_wr_row_i = '0;
    inv_rd_valid_i = 0; inv_rd_addr_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    step();
    rst_ni = 1;
    ref_written = '0;
    exp_err = 0;
  endtask

  task automatic load_all();
    int order [SIZE];
    int j, t;
    for (int i = 0; i < SIZE; i++) order[i] = i;
    for (int i = SIZE - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < SIZE; i++) begin
      host_wr_valid_i = 1;
      host_wr_addr_i  = AW'(order[i]);
      host_wr_row_i   = rand_row();
      step();
      ref_mem[order[i]] = host_wr_row_i;
      ref_written[order[i]] = 1'b1;
      n_checks++;
      if (full_o !== (&ref_written)) begin
        n_fail++; $display("FAIL load_full[%0d]: got %b exp %b", i, full_o, &ref_written);
      end
    end
    host_wr_valid_i = 0;
  endtask

  task automatic host_read_check(input int a, input string name);
    host_rd_valid_i = 1;
    host_rd_addr_i  = AW'(a);
    exp_q.push_back(ref_mem[a]);
    step();
    host_rd_valid_i = 0;
    exp_row = exp_q.pop_front();
    n_checks++;
    if (host_rd_valid_o !== 1'b1 || host_rd_addr_o !== AW'(a) || host_rd_row_o !== exp_row) begin
      n_fail++;
      $display("FAIL %s: valid=%b addr=%0d row=%h exp addr=%0d row=%h",
               name, host_rd_valid_o, host_rd_addr_o, host_rd_row_o, a, exp_row);
    end
  endtask

  task automatic lu_read_check(input int a, input string name);
    lu_rd_valid_i = 1;
    lu_rd_addr_i  = AW'(a);
    exp_q.push_back(ref_mem[a]);
    step();
    lu_rd_valid_i = 0;
    exp_row = exp_q.pop_front();
    n_checks++;
    if (lu_rd_valid_o !== 1'b1 || lu_rd_addr_o !== AW'(a) || lu_rd_row_o !== exp_row) begin
      n_fail++;
      $display("FAIL %s: valid=%b addr=%0d row=%h exp addr=%0d row=%h",
               name, lu_rd_valid_o, lu_rd_addr_o, lu_rd_row_o, a, exp_row);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({owner_o, full_o, err_o, host_wr_ready_o, lu_wr_ready_o} !== 6'b000010) begin
      n_fail++; $display("FAIL reset_status: got owner=%0d full=%b err=%b hrdy=%b lrdy=%b exp 0 0 0 1 0",
                         owner_o, full_o, err_o, host_wr_ready_o, lu_wr_ready_o);
    end
    n_checks++;
    if ({lu_start_o, inv_start_o, host_rd_valid_o, lu_rd_valid_o, inv_rd_valid_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b exp 00000",
                         {lu_start_o, inv_start_o, host_rd_valid_o, lu_rd_valid_o, inv_rd_valid_o});
    end
  endtask

  task automatic test_start_not_full();
    start_lu_i = 1;
    step();
    start_lu_i = 0;
    exp_err = 1;
    n_checks++;
    if (lu_start_o !== 1'b0 || owner_o !== 2'd0 || err_o !== exp_err) begin
      n_fail++; $display("FAIL start_not_full: pulse=%b owner=%0d err=%b exp 0 0 1", lu_start_o, owner_o, err_o);
    end
    do_reset();
  endtask

  task automatic test_load_readback();
    load_all();
    host_read_check(5, "readback_row5");
    for (int i = 0; i < 8; i++) host_read_check($urandom_range(SIZE - 1, 0), "readback_rand");
    step();
    n_checks++;
    if (host_rd_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL readback_valid_drop: got %b exp 0", host_rd_valid_o);
    end
  endtask

  task automatic test_clear();
    int a;
    a = $urandom_range(SIZE - 1, 0);
    host_wr_valid_i = 1; host_wr_addr_i = AW'(a); host_wr_row_i = rand_row(); clear_i = 1;
    step();
    host_wr_valid_i = 0; clear_i = 0;
    ref_mem[a] = host_wr_row_i;
    ref_written = '0;
    n_checks++;
    if (full_o !== 1'b0) begin
      n_fail++; $display("FAIL clear_wins: full=%b exp 0", full_o);
    end
    host_read_check(a, "clear_write_lands");
    load_all();
  endtask

  task automatic test_lu_run();
    int a;
    logic [ROW_W-1:0] old_row;
    start_lu_i = 1;
    step();
    start_lu_i = 0;
    n_checks++;
    if ({lu_start_o, inv_start_o, owner_o, lu_wr_ready_o, host_wr_ready_o} !== 6'b100110) begin
      n_fail++; $display("FAIL lu_start: pulse=%b inv=%b owner=%0d lrdy=%b hrdy=%b exp 1 0 1 1 0",
                         lu_start_o, inv_start_o, owner_o, lu_wr_ready_o, host_wr_ready_o);
    end
    lu_busy_i = 1;
    step();
    n_checks++;
    if (lu_start_o !== 1'b0 || owner_o !== 2'd1) begin
      n_fail++; $display("FAIL lu_pulse_once: pulse=%b owner=%0d exp 0 1", lu_start_o, owner_o);
    end
    for (int i = 0; i < SIZE; i++) lu_read_check(i, "lu_stream");
    lu_wr_valid_i = 1; lu_wr_addr_i = AW'(3); lu_wr_row_i = rand_row();
    step();
    lu_wr_valid_i = 0;
    ref_mem[3] = lu_wr_row_i;
    lu_read_check(3, "lu_writeback_row3");
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(SIZE - 1, 0);
      lu_wr_valid_i = 1; lu_wr_addr_i = AW'(a); lu_wr_row_i = rand_row();
      step();
      lu_wr_valid_i = 0;
      ref_mem[a] = lu_wr_row_i;
      lu_read_check(a, "lu_writeback_rand");
    end
    old_row = ref_mem[7];
    lu_rd_valid_i = 1; lu_rd_addr_i = AW'(7);
    lu_wr_valid_i = 1; lu_wr_addr_i = AW'(7); lu_wr_row_i = rand_row();
    step();
    lu_rd_valid_i = 0; lu_wr_valid_i = 0;
    ref_mem[7] = lu_wr_row_i;
    n_checks++;
    if (lu_rd_valid_o !== 1'b1 || lu_rd_row_o !== old_row) begin
      n_fail++; $display("FAIL collision_old: valid=%b row=%h exp %h", lu_rd_valid_o, lu_rd_row_o, old_row);
    end
    lu_read_check(7, "collision_new");
    n_checks++;
    if (full_o !== 1'b1 || err_o !== exp_err) begin
      n_fail++; $display("FAIL lu_bitmap_err: full=%b err=%b exp 1 %b", full_o, err_o, exp_err);
    end
    host_wr_valid_i = 1; host_wr_addr_i = AW'(9); host_wr_row_i = rand_row();
    n_checks++;
    if (host_wr_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL host_ready_in_run: got %b exp 0", host_wr_ready_o);
    end
    step();
    host_wr_valid_i = 0;
    exp_err = 1;
    n_checks++;
    if (err_o !== exp_err) begin
      n_fail++; $display("FAIL host_write_err: got %b exp 1", err_o);
    end
    lu_read_check(9, "host_write_dropped");
    inv_rd_valid_i = 1; inv_rd_addr_i = AW'(2);
    step();
    inv_rd_valid_i = 0;
    n_checks++;
    if (inv_rd_valid_o !== 1'b0 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL inv_nonowner: valid=%b err=%b exp 0 1", inv_rd_valid_o, err_o);
    end
    lu_busy_i = 0;
    step();
    n_checks++;
    if (owner_o !== 2'd0 || lu_wr_ready_o !== 1'b0 || host_wr_ready_o !== 1'b1 || full_o !== 1'b1) begin
      n_fail++; $display("FAIL lu_done: owner=%0d lrdy=%b hrdy=%b full=%b exp 0 0 1 1",
                         owner_o, lu_wr_ready_o, host_wr_ready_o, full_o);
    end
  endtask

  task automatic test_arbitration();
    start_lu_i = 1; start_inv_i = 1;
    step();
    start_lu_i = 0; start_inv_i = 0;
    n_checks++;
    if (lu_start_o !== 1'b1 || inv_start_o !== 1'b0 || owner_o !== 2'd1) begin
      n_fail++; $display("FAIL arbitration: lu=%b inv=%b owner=%0d exp 1 0 1", lu_start_o, inv_start_o, owner_o);
    end
    lu_busy_i = 1;
    step();
    lu_busy_i = 0;
    step();
    n_checks++;
    if (owner_o !== 2'd0 || inv_start_o !== 1'b0) begin
      n_fail++; $display("FAIL arbitration_end: owner=%0d inv=%b exp 0 0", owner_o, inv_start_o);
    end
  endtask

  task automatic test_inv_timeout_and_run();
    int a;
    do_reset();
    load_all();
    start_inv_i = 1;
    step();
    start_inv_i = 0;
    n_checks++;
    if (inv_start_o !== 1'b1 || lu_start_o !== 1'b0 || owner_o !== 2'd2 || lu_wr_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL inv_start: inv=%b lu=%b owner=%0d lrdy=%b exp 1 0 2 0",
                         inv_start_o, lu_start_o, owner_o, lu_wr_ready_o);
    end
    a = $urandom_range(SIZE - 1, 0);
    inv_rd_valid_i = 1; inv_rd_addr_i = AW'(a);
    step();
    inv_rd_valid_i = 0;
    n_checks++;
    if (inv_rd_valid_o !== 1'b1 || inv_rd_addr_o !== AW'(a) || inv_rd_row_o !== ref_mem[a]) begin
      n_fail++; $display("FAIL inv_wait_read: valid=%b addr=%0d row=%h exp %0d %h",
                         inv_rd_valid_o, inv_rd_addr_o, inv_rd_row_o, a, ref_mem[a]);
    end
    repeat (14) step();
    n_checks++;
    if (owner_o !== 2'd2 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: owner=%0d err=%b exp 2 0", owner_o, err_o);
    end
    step();
    exp_err = 1;
    n_checks++;
    if (owner_o !== 2'd0 || err_o !== exp_err) begin
      n_fail++; $display("FAIL timeout_expire: owner=%0d err=%b exp 0 1", owner_o, err_o);
    end
    start_inv_i = 1;
    step();
    start_inv_i = 0;
    inv_busy_i = 1;
    step();
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(SIZE - 1, 0);
      inv_rd_valid_i = 1; inv_rd_addr_i = AW'(a);
      step();
      n_checks++;
      if (inv_rd_valid_o !== 1'b1 || inv_rd_addr_o !== AW'(a) || inv_rd_row_o !== ref_mem[a]) begin
        n_fail++; $display("FAIL inv_run_read: valid=%b addr=%0d row=%h exp %0d %h",
                           inv_rd_valid_o, inv_rd_addr_o, inv_rd_row_o, a, ref_mem[a]);
      end
    end
    inv_rd_valid_i = 0;
    inv_busy_i = 0;
    step();
    n_checks++;
    if (owner_o !== 2'd0 || inv_rd_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL inv_done: owner=%0d valid=%b exp 0 0", owner_o, inv_rd_valid_o);
    end
  endtask

  task automatic test_reset_mid_run();
    start_lu_i = 1;
    step();
    start_lu_i = 0;
    lu_busy_i = 1;
    step();
    lu_rd_valid_i = 1; lu_rd_addr_i = AW'($urandom_range(SIZE - 1, 0));
    rst_ni = 0;
    step();
    rst_ni = 1;
    lu_rd_valid_i = 0; lu_busy_i = 0;
    ref_written = '0;
    exp_err = 0;
    n_checks++;
    if (lu_rd_valid_o !== 1'b0 || owner_o !== 2'd0 || full_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_run: valid=%b owner=%0d full=%b err=%b exp 0 0 0 0",
                         lu_rd_valid_o, owner_o, full_o, err_o);
    end
    for (int i = 0; i < SIZE; i++) host_read_check(i, "rows_retained");
  endtask

  initial begin
    rst_ni = 1;
    idle_inputs();
    step();
    test_reset();
    test_start_not_full();
    test_load_readback();
    test_clear();
    test_lu_run();
    test_arbitration();
    test_inv_timeout_and_run();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
